// File: rtl/pipe_shift_reg_pkg.sv
// pipe_shift_pkg: shared constants and helpers for the elastic pipeline register.
//   DEFAULT_WIDTH  default datapath width
//   cnt_w()        width of an occupancy counter able to hold 0..DEPTH
//   CLEAR_DATA     1 when PIPE_SHIFT_REG_CLEAR_DATA_EN is defined (data flops
//                  cleared on reset/flush/bubble), 0 otherwise
package pipe_shift_pkg;

    localparam int DEFAULT_WIDTH = 32;

`ifdef PIPE_SHIFT_REG_CLEAR_DATA_EN
    localparam bit CLEAR_DATA = 1'b1;
`else
    localparam bit CLEAR_DATA = 1'b0;
`endif

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_shift_reg_stage.sv
// pipe_shift_stage: one stage of the elastic pipeline (valid flop + data flop).
// Configuration macro: PIPE_SHIFT_REG_CLEAR_DATA_EN (zero data on reset, flush
// and whenever the stage becomes a bubble).
// Ports:
//   CLK, RST     clock, synchronous active-high reset
//   flush        drop the held entry at the next edge
//   adv          stage may load from its predecessor this cycle
//   prev_valid   valid bit of the predecessor (or the input accept)
//   prev_data    data of the predecessor (or in_data)
//   valid, data  stage contents
module pipe_shift_stage
    import pipe_shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             adv,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge CLK) begin
        if (RST || flush)
            valid <= 1'b0;
        else if (adv)
            valid <= prev_valid;
    end

`ifdef PIPE_SHIFT_REG_CLEAR_DATA_EN
    // Loading a bubble clears the data so an invalid stage always reads zero.
    always_ff @(posedge CLK) begin
        if (RST || flush)
            data <= '0;
        else if (adv)
            data <= prev_valid ? prev_data : '0;
    end
`else
    // No reset on data; only real items are loaded so an empty output keeps
    // the last delivered value.
    always_ff @(posedge CLK) begin
        if (adv && prev_valid)
            data <= prev_data;
    end
`endif

endmodule

// File: rtl/pipe_shift_reg.sv
// pipe_shift_reg: parameterised elastic pipeline register (DEPTH stages of
// WIDTH bits) with ready/valid at both ends, bubble collapsing and flush.
// Configuration macro: PIPE_SHIFT_REG_CLEAR_DATA_EN (see pipe_shift_stage).
// Ports:
//   CLK, RST               clock, synchronous active-high reset
//   in_valid/in_ready/in_data     producer side (in_ready is combinational)
//   out_valid/out_ready/out_data  consumer side, driven by the last stage
//   flush                  discard all entries at the next edge
//   occupancy              registered count of valid stages
module pipe_shift_reg
    import pipe_shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    input  logic                      flush,
    output logic [cnt_w(DEPTH)-1:0]   occupancy
);

    localparam int CW = cnt_w(DEPTH);

    logic [DEPTH-1:0]            v;
    logic [DEPTH-1:0]            adv;
    logic [DEPTH-1:0][WIDTH-1:0] d;
    logic                        accept;
    logic                        deliver;

    // adv[k] = adv[k+1] | ~v[k] unrolled: a stage advances unless it and every
    // stage downstream of it is valid while the consumer stalls. Writing it
    // flat keeps the vector free of bit-to-bit self dependencies.
    for (genvar k = 0; k < DEPTH; k++) begin : g_adv
        assign adv[k] = out_ready | ~(&v[DEPTH-1:k]);
    end

    assign in_ready  = adv[0] & ~flush;
    assign accept    = in_valid & in_ready;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign deliver   = out_valid & out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             pv;
        logic [WIDTH-1:0] pd;
        if (k == 0) begin : g_head
            assign pv = accept;
            assign pd = in_data;
        end else begin : g_body
            assign pv = v[k-1];
            assign pd = d[k-1];
        end

        pipe_shift_stage #(.WIDTH(WIDTH)) u_stage (
            .CLK        (CLK),
            .RST        (RST),
            .flush      (flush),
            .adv        (adv[k]),
            .prev_valid (pv),
            .prev_data  (pd),
            .valid      (v[k]),
            .data       (d[k])
        );
    end

    // Flush empties every stage, so the count drops to zero even if an item
    // is also delivered in that cycle.
    always_ff @(posedge CLK) begin
        if (RST || flush)
            occupancy <= '0;
        else
            occupancy <= occupancy + CW'(accept) - CW'(deliver);
    end

endmodule

// File: tb/tb_pipe_shift_reg.sv
// tb_pipe_shift_reg: randomized self-checking bench. Four instances
// (DEPTH = 1..4) are driven independently and compared against an item-level
// model: a queue of in-flight items, each tagged with its stage position.
module tb_pipe_shift_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        localparam int D = gi + 1;

        logic                      rst, iv, ir, ov, ordy, fl;
        logic [31:0]               idata, odata;
        logic [$clog2(D+1)-1:0]    occ;

        int          qp[$];   // stage position of each in-flight item, oldest first
        logic [31:0] qd[$];   // data of each in-flight item

        pipe_shift_reg #(.WIDTH(32), .DEPTH(D)) dut (
            .CLK       (clk),
            .RST       (rst),
            .in_valid  (iv),
            .in_ready  (ir),
            .in_data   (idata),
            .out_valid (ov),
            .out_ready (ordy),
            .out_data  (odata),
            .flush     (fl),
            .occupancy (occ)
        );

        initial begin : stim
            bit    mrdy, acc, ovm;
            int    prev, p;
            string pfx;
            pfx = $sformatf("d%0d", D);
            rst = 1'b1; iv = 1'b0; fl = 1'b0; ordy = 1'b0; idata = '0;
            repeat (2) @(posedge clk);
            #1;
            chk({pfx, " rst ov"}, 32'(ov), 32'd0);
            chk({pfx, " rst occ"}, 32'(occ), 32'd0);
`ifdef PIPE_SHIFT_REG_CLEAR_DATA_EN
            chk({pfx, " rst data"}, odata, 32'd0);
`endif
            rst = 1'b0;
            #1;
            chk({pfx, " rst rdy"}, 32'(ir), 32'd1);

            for (int cyc = 0; cyc < 800; cyc++) begin
                rst   = ($urandom_range(0, 149) == 0);
                fl    = ($urandom_range(0, 39) == 0);
                iv    = ($urandom_range(0, 9) < 7);
                idata = $urandom;
                case ((cyc / 40) % 3)
                    0:       ordy = 1'b1;
                    1:       ordy = ($urandom_range(0, 3) == 0);
                    default: ordy = $urandom_range(0, 1);
                endcase
                #1;
                // The block only refuses input when completely full and stalled.
                mrdy = !fl && !(qd.size() == D && !ordy);
                chk({pfx, " rdy"}, 32'(ir), 32'(mrdy));
                acc = iv && mrdy;

                @(posedge clk);
                #1;
                if (rst || fl) begin
                    qp.delete();
                    qd.delete();
                end else begin
                    if (qp.size() > 0 && qp[0] == D - 1 && ordy) begin
                        void'(qp.pop_front());
                        void'(qd.pop_front());
                    end
                    // Each item steps forward unless the item ahead of it
                    // ended up directly in front.
                    prev = -1;
                    for (int i = 0; i < qp.size(); i++) begin
                        p = qp[i];
                        if (p != D - 1 && prev != p + 1)
                            qp[i] = p + 1;
                        prev = qp[i];
                    end
                    if (acc) begin
                        qp.push_back(0);
                        qd.push_back(idata);
                    end
                end

                ovm = (qp.size() > 0 && qp[0] == D - 1);
                chk({pfx, " ov"}, 32'(ov), 32'(ovm));
                chk({pfx, " occ"}, 32'(occ), 32'(qd.size()));
                if (ovm)
                    chk({pfx, " data"}, odata, qd[0]);
`ifdef PIPE_SHIFT_REG_CLEAR_DATA_EN
                else
                    chk({pfx, " zero"}, odata, 32'd0);
`endif
            end
            done++;
        end
    end

    initial begin
        int n;
        n = 0;
        while (done < 4 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (done < 4) chk("timeout", 32'(done), 32'd4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_shift_reg.md
# pipe_shift_reg

Parametrised elastic pipeline register for the MIPS datapath: a chain of DEPTH stages, each WIDTH bits wide, with a per-stage valid bit, ready/valid handshake at both ends, bubble collapsing, and a flush. It generalises the plain 32-bit clocked data register between CPU stages. Use it for inter-stage latches, multi-cycle unit delay lines and short result queues.

## Interface
- WIDTH, 32: data width in bits, ≥1
- DEPTH, 1: number of register stages, ≥1
- CLK  input  1  clock; all state updates on the rising edge
- RST  input  1  synchronous reset, active-high
- in_valid  input  1  producer offers in_data this cycle
- in_ready  output  1  block accepts in_data this cycle (combinational)
- in_data  input  WIDTH  producer data
- out_valid  output  1  stage DEPTH-1 holds valid data
- out_ready  input  1  consumer takes out_data this cycle
- out_data  output  WIDTH  data of stage DEPTH-1
- flush  input  1  discard all held entries
- occupancy  output  $clog2(DEPTH+1)  registered count of valid stages

## Operation
- Stage k holds v[k] and d[k]. Stage 0 is the input side; stage DEPTH-1 is the output side.
- out_valid = v[DEPTH-1]; out_data = d[DEPTH-1].
- Advance rule, evaluated combinationally from the output side:
  - adv[DEPTH-1] = out_ready | ~v[DEPTH-1]
  - adv[k] = adv[k+1] | ~v[k]
- in_ready = adv[0] & ~flush.
- On the clock edge, for each stage with adv[k]=1:
  - stage k loads from stage k-1
  - stage 0 loads in_data, with valid in_valid & in_ready
- A stage with adv[k]=0 holds its contents.
- Bubbles collapse: an invalid stage is always overwritten, even while out_ready=0.
- Flush: at the next edge every v[k] becomes 0, and occupancy becomes 0.
  - Flush has priority over acceptance and transfer; a simultaneous input is dropped, since in_ready is already 0.
  - An output handshake in the flush cycle (out_valid & out_ready) still counts as delivered.
- Occupancy update: occupancy_next = occupancy + accept − deliver.
  - accept = in_valid & in_ready; deliver = out_valid & out_ready.
  - Never exceeds DEPTH and never underflows.
- Full (occupancy=DEPTH): in_ready = out_ready. Simultaneous accept and deliver leaves occupancy unchanged.
- Empty: out_valid=0. out_data keeps its last content, or zero under the configuration macro.

## Timing
- Reset (RST=1 at an edge): all v[k]=0, occupancy=0, out_valid=0.
  - in_ready is 1 when RST=0 and flush=0.
  - Data registers are don't-care unless the macro is defined.
- RST asserted mid-operation: identical to reset; all entries are lost. RST overrides flush.
- Latency: an item accepted at edge n appears on out_valid after edge n+DEPTH−1. Total DEPTH cycles from in_valid to out_valid with out_ready held high.
- Throughput: one item per cycle when out_ready=1.
- in_ready depends combinationally on out_ready, through a ripple of DEPTH gates. No other comb paths from inputs to outputs.

## Configuration
- PIPE_SHIFT_REG_CLEAR_DATA_EN
  - Defined: every d[k] is forced to 0 on RST, and on flush. A stage's data is zeroed whenever it goes invalid without being reloaded, so out_data=0 whenever out_valid=0.
  - Undefined: only valid bits are cleared. Data registers carry no reset, which saves area, and out_data is undefined while out_valid=0.

## Structure
- Package pipe_shift_pkg holds:
  - the default WIDTH (32)
  - the count-width function (clog2(DEPTH+1))
  - the macro name check
- Sub-module pipe_shift_stage holds one stage: valid flop plus WIDTH data flop, with load, flush and clear logic. The top generates DEPTH instances plus the adv chain and the occupancy counter.

## Test plan
- Reset: RST=1 for 2 cycles, then 0 → out_valid=0, occupancy=0, in_ready=1. With the macro defined, out_data=0.
- Streaming, DEPTH=3, out_ready=1: push 0x11,0x22,0x33 on consecutive cycles → 0x11 appears out 3 cycles after accept, then one item per cycle in order. Occupancy peaks at 3.
- Backpressure and bubble collapse, DEPTH=4, out_ready=0: push A, idle one cycle, push B,C,D → all four accepted, occupancy=4, in_ready=0. Release out_ready → A,B,C,D delivered in order.
- Full with simultaneous push and pop, DEPTH=2: occupancy=2, out_ready=1, in_valid=1 → in_ready=1, occupancy stays 2, order preserved.
- Flush: occupancy=3, assert flush with in_valid=1 → in_ready=0, the input is dropped, next cycle occupancy=0 and out_valid=0.
- Reset mid-stream: RST pulsed while occupancy=2 and flush=1 → occupancy=0 and no stale item ever appears on the output.
